// File: rtl/snoop_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_dispatch_pkg
//  Purpose  : Shared FSM state encoding and grant-index width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package snoop_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ARMED  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    function automatic int grant_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_dispatch_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin first-set search starting after i_last.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import snoop_dispatch_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = grant_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_last,
    output logic          o_found,
    output logic [GW-1:0] o_idx
);

    logic [GW-1:0] w_cand;

    // Offsets 1..N visit every index once, ending on i_last itself.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = GW'((int'(i_last) + k) % N);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snoop_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_dispatch
//  Purpose  : Routes snooper packets to one of N free buffers, dropping
//             packets when none is armed. SNOOP_DISPATCH_DROP_CNT_EN enables
//             the saturating dropped-packet counter.
//  Revision : 1.0 - initial release
// ============================================================================
module snoop_dispatch
    import snoop_dispatch_pkg::*;
#(
    parameter int N              = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 64,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      axi_aclk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0]     snooper_wr_data,
    input  logic                      snooper_wr_en,
    input  logic                      snooper_done,
    output logic                      ready_for_snooper,
    input  logic [N-1:0]              buf_ready,
    output logic [ADDR_WIDTH-1:0]     buf_wr_addr,
    output logic [DATA_WIDTH-1:0]     buf_wr_data,
    output logic [N-1:0]              buf_wr_en,
    output logic [N-1:0]              buf_done,
    output logic [$clog2(N)-1:0]      grant_idx,
    output logic [DROP_CNT_WIDTH-1:0] num_packets_dropped
);

    localparam int GW = grant_width(N);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant_idx;
    logic [GW-1:0]         w_grant_nxt;
    logic [GW-1:0]         w_pick_idx;
    logic                  w_found;
    logic                  w_fwd_en;
    logic                  w_fwd_done;
    logic [N-1:0]          w_onehot;
    logic [N-1:0]          r_buf_wr_en;
    logic [N-1:0]          r_buf_done;
    logic [ADDR_WIDTH-1:0] r_buf_wr_addr;
    logic [DATA_WIDTH-1:0] r_buf_wr_data;

    rr_pick #(
        .N  (N),
        .GW (GW)
    ) u_rr_pick (
        .i_req   (buf_ready),
        .i_last  (r_grant_idx),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_onehot = {{(N-1){1'b0}}, 1'b1} << r_grant_idx;

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_grant_idx <= GW'(N - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_fwd_en    = 1'b0;
        w_fwd_done  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                // A beat arriving with nothing armed owns the rest of its packet.
                if (snooper_wr_en) begin
                    if (!snooper_done) begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (w_found) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (snooper_wr_en) begin
                    w_fwd_en = 1'b1;
                    if (snooper_done) begin
                        w_fwd_done  = 1'b1;
                        w_state_nxt = ST_SEARCH;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end else if (!buf_ready[r_grant_idx]) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_BUSY: begin
                w_fwd_en = snooper_wr_en;
                if (snooper_done) begin
                    w_fwd_done  = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_DROP: begin
                if (snooper_done) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_buf_wr_en   <= '0;
            r_buf_done    <= '0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
        end else begin
            r_buf_wr_en   <= w_fwd_en   ? w_onehot : '0;
            r_buf_done    <= w_fwd_done ? w_onehot : '0;
            r_buf_wr_addr <= snooper_wr_addr;
            r_buf_wr_data <= snooper_wr_data;
        end
    end

    assign ready_for_snooper = (r_state == ST_ARMED) || (r_state == ST_BUSY);
    assign buf_wr_en         = r_buf_wr_en;
    assign buf_done          = r_buf_done;
    assign buf_wr_addr       = r_buf_wr_addr;
    assign buf_wr_data       = r_buf_wr_data;
    assign grant_idx         = r_grant_idx;

`ifdef SNOOP_DISPATCH_DROP_CNT_EN
    logic                      w_drop_inc;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    // Single-cycle drops in SEARCH are counted without visiting DROP.
    assign w_drop_inc = snooper_done &&
                        (((r_state == ST_SEARCH) && snooper_wr_en) || (r_state == ST_DROP));

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign num_packets_dropped = r_drop_cnt;
`else
    assign num_packets_dropped = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snoop_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snoop_dispatch
//  Purpose  : Table-driven self-checking bench for snoop_dispatch (N=4,
//             2-bit drop counter) plus a hand-written post-reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_dispatch;

`ifdef SNOOP_DISPATCH_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  snooper_wr_addr;
    logic [63:0] snooper_wr_data;
    logic        snooper_wr_en;
    logic        snooper_done;
    logic        ready_for_snooper;
    logic [3:0]  buf_ready;
    logic [8:0]  buf_wr_addr;
    logic [63:0] buf_wr_data;
    logic [3:0]  buf_wr_en;
    logic [3:0]  buf_done;
    logic [1:0]  grant_idx;
    logic [1:0]  num_packets_dropped;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    snoop_dispatch #(
        .N              (4),
        .ADDR_WIDTH     (9),
        .DATA_WIDTH     (64),
        .DROP_CNT_WIDTH (2)
    ) dut (
        .axi_aclk            (clk),
        .rst                 (rst),
        .snooper_wr_addr     (snooper_wr_addr),
        .snooper_wr_data     (snooper_wr_data),
        .snooper_wr_en       (snooper_wr_en),
        .snooper_done        (snooper_done),
        .ready_for_snooper   (ready_for_snooper),
        .buf_ready           (buf_ready),
        .buf_wr_addr         (buf_wr_addr),
        .buf_wr_data         (buf_wr_data),
        .buf_wr_en           (buf_wr_en),
        .buf_done            (buf_done),
        .grant_idx           (grant_idx),
        .num_packets_dropped (num_packets_dropped)
    );

    typedef struct {
        logic       rst;
        logic [3:0] rdy_in;
        logic       we;
        logic       dn;
        logic       e_rdy;
        logic [3:0] e_wr;
        logic [3:0] e_dn;
        logic [1:0] e_gr;
        logic [1:0] e_drop;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [3:0] ri, input logic we,
                                input logic dn, input logic erdy, input logic [3:0] ewr,
                                input logic [3:0] edn, input logic [1:0] egr,
                                input logic [1:0] edrop);
        vec_t v;
        v.rst = r; v.rdy_in = ri; v.we = we; v.dn = dn;
        v.e_rdy = erdy; v.e_wr = ewr; v.e_dn = edn; v.e_gr = egr; v.e_drop = edrop;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0]  a_in;
        logic [63:0] d_in;
        logic [1:0]  exp_drop;
        int          waited;
        int          pulses;

        // Outputs after each row's edge; forwarded addr/data equal that row's inputs.
        vq.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 4'h0, 2'd3, 2'd0)); // 0  reset
        vq.push_back(mk(0, 4'hF, 0, 0, 1, 4'h0, 4'h0, 2'd0, 2'd0)); // 1  first pick = 0
        vq.push_back(mk(0, 4'hF, 0, 0, 1, 4'h0, 4'h0, 2'd0, 2'd0)); // 2
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h1, 4'h0, 2'd0, 2'd0)); // 3  packet A
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h1, 4'h0, 2'd0, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h1, 4'h0, 2'd0, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 1, 0, 4'h1, 4'h1, 2'd0, 2'd0)); // 6
        vq.push_back(mk(0, 4'hF, 0, 0, 1, 4'h0, 4'h0, 2'd1, 2'd0)); // 7  pick 1
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h2, 4'h0, 2'd1, 2'd0)); // 8  packet B
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h2, 4'h0, 2'd1, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h2, 4'h0, 2'd1, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 1, 0, 4'h2, 4'h2, 2'd1, 2'd0)); // 11
        vq.push_back(mk(0, 4'hF, 0, 0, 1, 4'h0, 4'h0, 2'd2, 2'd0)); // 12 pick 2
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h4, 4'h0, 2'd2, 2'd0)); // 13 packet C
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h4, 4'h0, 2'd2, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 0, 1, 4'h4, 4'h0, 2'd2, 2'd0));
        vq.push_back(mk(0, 4'hF, 1, 1, 0, 4'h4, 4'h4, 2'd2, 2'd0)); // 16
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 2'd2, 2'd0)); // 17 nothing free
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 2'd2, 2'd0)); // 18 dropped packet
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 2'd2, 2'd0));
        vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 2'd2, 2'd1)); // 20
        vq.push_back(mk(0, 4'h4, 0, 0, 1, 4'h0, 4'h0, 2'd2, 2'd1)); // 21 only buf 2
        vq.push_back(mk(0, 4'h4, 1, 1, 0, 4'h4, 4'h4, 2'd2, 2'd1)); // 22 single beat
        vq.push_back(mk(0, 4'h4, 0, 0, 1, 4'h0, 4'h0, 2'd2, 2'd1)); // 23
        vq.push_back(mk(0, 4'h4, 0, 1, 1, 4'h0, 4'h0, 2'd2, 2'd1)); // 24 stray done
        vq.push_back(mk(0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 2'd2, 2'd1)); // 25 ready falls
        vq.push_back(mk(0, 4'h9, 0, 0, 1, 4'h0, 4'h0, 2'd3, 2'd1)); // 26 pick 3
        vq.push_back(mk(0, 4'h9, 1, 0, 1, 4'h8, 4'h0, 2'd3, 2'd1)); // 27
        vq.push_back(mk(0, 4'h0, 1, 0, 1, 4'h8, 4'h0, 2'd3, 2'd1)); // 28 ready drops in BUSY
        vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'h8, 4'h8, 2'd3, 2'd1)); // 29
        vq.push_back(mk(0, 4'h1, 0, 0, 1, 4'h0, 4'h0, 2'd0, 2'd1)); // 30 wrap to 0
        vq.push_back(mk(0, 4'h1, 1, 0, 1, 4'h1, 4'h0, 2'd0, 2'd1)); // 31
        vq.push_back(mk(1, 4'h1, 1, 0, 0, 4'h0, 4'h0, 2'd3, 2'd0)); // 32 reset mid-packet
        vq.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 4'h0, 2'd3, 2'd0)); // 33 trailing beat
        vq.push_back(mk(0, 4'h1, 1, 1, 0, 4'h0, 4'h0, 2'd3, 2'd1)); // 34
        vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 2'd3, 2'd2)); // 35 same-cycle drops
        vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 2'd3, 2'd3));
        vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 2'd3, 2'd3)); // 37 saturated
        vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 4'h0, 2'd3, 2'd3));
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 4'h0, 4'h0, 2'd3, 2'd3)); // 39
        vq.push_back(mk(0, 4'h0, 0, 1, 0, 4'h0, 4'h0, 2'd3, 2'd3)); // 40 done ignored

        for (int i = 0; i < vq.size(); i++) begin
            a_in = 9'((i * 37 + 5) % 512);
            d_in = 64'hDEAD_BEEF_0000_0000 ^ 64'(i * 1234567);
            rst             = vq[i].rst;
            buf_ready       = vq[i].rdy_in;
            snooper_wr_en   = vq[i].we;
            snooper_done    = vq[i].dn;
            snooper_wr_addr = a_in;
            snooper_wr_data = d_in;
            tick();
            n_vec++;
            exp_drop = CNT_EN ? vq[i].e_drop : 2'd0;
            chk("ready_for_snooper", i, 64'(ready_for_snooper), 64'(vq[i].e_rdy));
            chk("buf_wr_en", i, 64'(buf_wr_en), 64'(vq[i].e_wr));
            chk("buf_done", i, 64'(buf_done), 64'(vq[i].e_dn));
            chk("grant_idx", i, 64'(grant_idx), 64'(vq[i].e_gr));
            chk("num_packets_dropped", i, 64'(num_packets_dropped), 64'(exp_drop));
            chk("buf_wr_addr", i, 64'(buf_wr_addr), vq[i].rst ? 64'd0 : 64'(a_in));
            chk("buf_wr_data", i, buf_wr_data, vq[i].rst ? 64'd0 : d_in);
        end

        // Fresh reset with only buffer 1 free, then a 2-beat packet to it.
        rst = 1'b1; buf_ready = 4'b0010; snooper_wr_en = 1'b0; snooper_done = 1'b0;
        tick();
        rst = 1'b0;
        waited = 0;
        tick();
        while (!ready_for_snooper && waited < 8) begin
            tick();
            waited++;
        end
        n_vec++;
        if (!ready_for_snooper) begin
            n_miss++;
            $display("FAIL hs_ready_timeout: got ready=0 after %0d cycles expected 1", waited);
        end
        chk("hs_grant", 100, 64'(grant_idx), 64'd1);
        chk("hs_drops", 100, 64'(num_packets_dropped), 64'd0);

        snooper_wr_en = 1'b1; snooper_wr_addr = 9'h1A5; snooper_wr_data = 64'h0123_4567_89AB_CDEF;
        tick();
        n_vec++;
        chk("hs_beat0_en", 101, 64'(buf_wr_en), 64'h2);
        chk("hs_beat0_addr", 101, 64'(buf_wr_addr), 64'h1A5);
        snooper_done = 1'b1; snooper_wr_addr = 9'h1A6; snooper_wr_data = 64'hFEDC_BA98_7654_3210;
        tick();
        n_vec++;
        chk("hs_beat1_data", 102, buf_wr_data, 64'hFEDC_BA98_7654_3210);
        snooper_wr_en = 1'b0; snooper_done = 1'b0;
        pulses = (buf_done == 4'b0010) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (buf_done != 4'b0000) pulses++;
        end
        n_vec++;
        chk("hs_done_pulses", 103, 64'(pulses), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
